// File: rtl/sdram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sdram_pkg
// Description : Shared constants for the SDRAM read-burst controller: FSM
//               state encoding and default burst / FIFO sizing.
// Revision    : 1.0 - initial release
// ============================================================================
package sdram_pkg;

    // Default sizing: 256-word bursts into a 1024-deep read FIFO, refilled
    // whenever it drops below half full.
    localparam int unsigned c_burst_len_def = 256;
    localparam int unsigned c_fifo_aw_def   = 10;
    localparam int unsigned c_low_wm_def    = 512;

    // Read-burst FSM state encoding
    localparam int unsigned c_state_w = 2;
    localparam logic [c_state_w-1:0] c_st_idle = 2'd0;
    localparam logic [c_state_w-1:0] c_st_req  = 2'd1;
    localparam logic [c_state_w-1:0] c_st_data = 2'd2;
    localparam logic [c_state_w-1:0] c_st_adv  = 2'd3;

endpackage
`default_nettype wire

// File: rtl/burst_addr_gen.sv
`default_nettype none
// ============================================================================
// Module      : burst_addr_gen
// Description : Holds the current burst start address, advances it by one
//               burst with wrap-around to the region start, and applies
//               frame restarts either immediately or after the burst in
//               flight has completed.
// Revision    : 1.0 - initial release
// ============================================================================
module burst_addr_gen
    import sdram_pkg::*;
#(
    parameter int ADDR_W    = 24,
    parameter int BURST_LEN = c_burst_len_def
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] i_start_addr,
    input  logic [ADDR_W-1:0] i_end_addr,
    input  logic              i_restart_now,
    input  logic              i_restart_defer,
    input  logic              i_advance,
    output logic [ADDR_W-1:0] o_addr
);

    // One extra bit so a sum running past the top of the address space is
    // seen as larger than end_addr rather than silently wrapping to zero.
    localparam logic [ADDR_W:0] c_burst_inc = (ADDR_W+1)'(BURST_LEN);

    logic [ADDR_W-1:0] r_addr;
    logic              r_restart_pend;
    logic [ADDR_W:0]   w_sum;
    logic              w_wrap;

    assign w_sum  = {1'b0, r_addr} + c_burst_inc;
    assign w_wrap = w_sum > {1'b0, i_end_addr};
    assign o_addr = r_addr;

    // Address register and deferred-restart latch.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr         <= i_start_addr;
            r_restart_pend <= 1'b0;
        end else if (i_advance) begin
            // A restart seen during the burst (or in this very cycle) wins
            // over the normal increment.
            r_restart_pend <= 1'b0;
            if (r_restart_pend || i_restart_defer || w_wrap) begin
                r_addr <= i_start_addr;
            end else begin
                r_addr <= w_sum[ADDR_W-1:0];
            end
        end else begin
            if (i_restart_defer) begin
                r_restart_pend <= 1'b1;
            end
            if (i_restart_now) begin
                r_addr <= i_start_addr;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/sdram_rd_burst_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sdram_rd_burst_ctrl
// Description : Keeps a read FIFO topped up from an SDRAM frame buffer by
//               issuing fixed-length read bursts whenever the FIFO fill level
//               is below the low watermark, and forwards returned beats into
//               the FIFO one cycle later.
// Revision    : 1.0 - initial release
// ============================================================================
module sdram_rd_burst_ctrl
    import sdram_pkg::*;
#(
    parameter int ADDR_W    = 24,
    parameter int BURST_LEN = c_burst_len_def,
    parameter int FIFO_AW   = c_fifo_aw_def,
    parameter int LOW_WM    = c_low_wm_def
) (
    input  logic               clk,
    input  logic               aclr,
    input  logic               enable,
    input  logic               frame_restart,
    input  logic [ADDR_W-1:0]  start_addr,
    input  logic [ADDR_W-1:0]  end_addr,
    input  logic [FIFO_AW-1:0] fifo_wrusedw,
    output logic               rd_req,
    output logic [ADDR_W-1:0]  rd_addr,
    input  logic               rd_ack,
    input  logic               rd_valid,
    input  logic [15:0]        rd_data,
    output logic               fifo_wrreq,
    output logic [15:0]        fifo_data,
    output logic               busy,
    output logic               err_overrun
);

    localparam int                 c_cnt_w     = $clog2(BURST_LEN) + 1;
    localparam logic [c_cnt_w-1:0] c_last_beat = c_cnt_w'(BURST_LEN - 1);
    localparam logic [FIFO_AW:0]   c_low_wm    = (FIFO_AW+1)'(LOW_WM);

    logic [c_state_w-1:0] r_state;
    logic [c_cnt_w-1:0]   r_beat_cnt;
    logic                 r_rd_req;
    logic                 r_busy;
    logic                 r_fifo_wrreq;
    logic [15:0]          r_fifo_data;
    logic                 r_err_overrun;

    logic w_beat;
    logic w_start;
    logic w_fifo_full;
    logic w_restart_now;
    logic w_restart_defer;

    // Beats only count while a burst is being received; stray rd_valid
    // elsewhere is neither counted nor written to the FIFO.
    assign w_beat      = rd_valid && (r_state == c_st_data);
    assign w_start     = enable && ({1'b0, fifo_wrusedw} < c_low_wm);
    assign w_fifo_full = &fifo_wrusedw;

    // Before the controller has accepted the request the address can still
    // be redirected; once accepted the restart waits for the burst to end.
    assign w_restart_now   = frame_restart &&
                             ((r_state == c_st_idle) ||
                              ((r_state == c_st_req) && !rd_ack));
    assign w_restart_defer = frame_restart && !w_restart_now;

    burst_addr_gen #(
        .ADDR_W    (ADDR_W),
        .BURST_LEN (BURST_LEN)
    ) u_addr_gen (
        .clk             (clk),
        .rst             (aclr),
        .i_start_addr    (start_addr),
        .i_end_addr      (end_addr),
        .i_restart_now   (w_restart_now),
        .i_restart_defer (w_restart_defer),
        .i_advance       (r_state == c_st_adv),
        .o_addr          (rd_addr)
    );

    // Burst sequencing FSM with registered request and busy flags.
    always_ff @(posedge clk) begin
        if (aclr) begin
            r_state    <= c_st_idle;
            r_rd_req   <= 1'b0;
            r_busy     <= 1'b0;
            r_beat_cnt <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_start) begin
                        r_state  <= c_st_req;
                        r_rd_req <= 1'b1;
                        r_busy   <= 1'b1;
                    end
                end
                c_st_req: begin
                    if (rd_ack) begin
                        r_state  <= c_st_data;
                        r_rd_req <= 1'b0;
                    end
                end
                c_st_data: begin
                    if (w_beat) begin
                        if (r_beat_cnt == c_last_beat) begin
                            r_beat_cnt <= '0;
                            r_state    <= c_st_adv;
                            r_busy     <= 1'b0;
                        end else begin
                            r_beat_cnt <= r_beat_cnt + c_cnt_w'(1);
                        end
                    end
                end
                c_st_adv: begin
                    r_state <= c_st_idle;
                end
                default: begin
                    r_state  <= c_st_idle;
                    r_rd_req <= 1'b0;
                    r_busy   <= 1'b0;
                end
            endcase
        end
    end

    // FIFO write path (one-cycle pipeline) and sticky overrun flag.
    always_ff @(posedge clk) begin
        if (aclr) begin
            r_fifo_wrreq  <= 1'b0;
            r_fifo_data   <= '0;
            r_err_overrun <= 1'b0;
        end else begin
            r_fifo_wrreq <= w_beat;
            if (w_beat) begin
                r_fifo_data <= rd_data;
            end
            if (w_beat && w_fifo_full) begin
                r_err_overrun <= 1'b1;
            end
        end
    end

    assign rd_req      = r_rd_req;
    assign busy        = r_busy;
    assign fifo_wrreq  = r_fifo_wrreq;
    assign fifo_data   = r_fifo_data;
    assign err_overrun = r_err_overrun;

endmodule
`default_nettype wire

// File: tb/tb_sdram_rd_burst_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_sdram_rd_burst_ctrl
// Description : Self-checking bench for sdram_rd_burst_ctrl. A transaction-
//               level model predicts each burst address and the FIFO write
//               stream; a per-cycle compare process checks the DUT against it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sdram_rd_burst_ctrl;

    localparam int c_burst = 256;

    logic        clk = 1'b0;
    logic        aclr;
    logic        enable;
    logic        frame_restart;
    logic [23:0] start_addr;
    logic [23:0] end_addr;
    logic [9:0]  fifo_wrusedw;
    logic        rd_req;
    logic [23:0] rd_addr;
    logic        rd_ack;
    logic        rd_valid;
    logic [15:0] rd_data;
    logic        fifo_wrreq;
    logic [15:0] fifo_data;
    logic        busy;
    logic        err_overrun;

    always #5 clk = ~clk;

    sdram_rd_burst_ctrl dut (
        .clk           (clk),
        .aclr          (aclr),
        .enable        (enable),
        .frame_restart (frame_restart),
        .start_addr    (start_addr),
        .end_addr      (end_addr),
        .fifo_wrusedw  (fifo_wrusedw),
        .rd_req        (rd_req),
        .rd_addr       (rd_addr),
        .rd_ack        (rd_ack),
        .rd_valid      (rd_valid),
        .rd_data       (rd_data),
        .fifo_wrreq    (fifo_wrreq),
        .fifo_data     (fifo_data),
        .busy          (busy),
        .err_overrun   (err_overrun)
    );

    int          checks = 0;
    int          errors = 0;
    int          wr_count = 0;
    logic [15:0] exp_q[$];
    logic [23:0] exp_req_addr;
    bit          model_err = 1'b0;
    bit          restart_pend = 1'b0;
    bit          cmp_en = 1'b0;
    logic [15:0] data_seed = 16'hA5A5;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Next burst address from the region rules, using wide integer math.
    function automatic logic [23:0] model_next(input logic [23:0] cur);
        longint s;
        s = longint'(cur) + longint'(c_burst);
        if (s > longint'(end_addr)) return start_addr;
        return 24'(s);
    endfunction

    task automatic model_advance();
        exp_req_addr = restart_pend ? start_addr : model_next(exp_req_addr);
        restart_pend = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(input string name);
        int n = 0;
        while (!rd_req && n < 300) begin
            tick();
            n++;
        end
        check({name, "_req_seen"}, rd_req, 1);
    endtask

    task automatic ack_req();
        rd_ack = 1'b1;
        tick();
        rd_ack = 1'b0;
    endtask

    task automatic send_beats(input int n, input int restart_at, input int full_at);
        logic [9:0] base_usedw;
        base_usedw = fifo_wrusedw;
        for (int i = 0; i < n; i++) begin
            rd_valid = 1'b1;
            rd_data  = data_seed;
            data_seed = data_seed * 16'd5 + 16'h3C1;
            exp_q.push_back(rd_data);
            if (i == restart_at) begin
                frame_restart = 1'b1;
                restart_pend  = 1'b1;
            end
            if (i == full_at) fifo_wrusedw = 10'h3FF;
            tick();
            if (i == full_at) model_err = 1'b1;
            frame_restart = 1'b0;
            fifo_wrusedw  = base_usedw;
        end
        rd_valid = 1'b0;
    endtask

    task automatic do_burst(input string name, input int restart_at);
        wait_req(name);
        ack_req();
        send_beats(c_burst, restart_at, -1);
        model_advance();
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (cmp_en && !aclr) begin
            if (rd_req) begin
                check("req_addr", rd_addr, exp_req_addr);
                check("busy_in_req", busy, 1);
            end
            if (fifo_wrreq) begin
                wr_count++;
                if (exp_q.size() == 0) check("wrreq_unexpected", fifo_wrreq, 0);
                else check("fifo_data", fifo_data, exp_q.pop_front());
            end
            check("err_overrun", err_overrun, model_err);
        end
    end

    initial begin
        int  n;
        bit  any_req;
        aclr = 1'b1; enable = 1'b0; frame_restart = 1'b0;
        start_addr = 24'h000000; end_addr = 24'h0003FF;
        fifo_wrusedw = 10'd0; rd_ack = 1'b0; rd_valid = 1'b0; rd_data = 16'h0;
        repeat (3) tick();

        check("rst_rd_req", rd_req, 0);
        check("rst_fifo_wrreq", fifo_wrreq, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err_overrun, 0);
        check("rst_fifo_data", fifo_data, 0);
        check("rst_rd_addr", rd_addr, 24'h000000);

        // Cold start
        exp_req_addr = start_addr;
        cmp_en = 1'b1;
        enable = 1'b1;
        aclr   = 1'b0;
        n = 0;
        while (!rd_req && n < 5) begin
            tick();
            n++;
        end
        check("cold_req_latency", (n <= 2), 1);
        check("cold_rd_addr", rd_addr, 24'h000000);
        wr_count = 0;
        do_burst("b0", -1);
        repeat (3) tick();
        check("cold_wr_count", wr_count, 256);
        wait_req("b1");
        check("second_rd_addr", rd_addr, 24'h000100);

        // Wrap after four bursts
        do_burst("b1", -1);
        do_burst("b2", -1);
        do_burst("b3", -1);
        wait_req("b4");
        check("wrap_fifth_addr", rd_addr, 24'h000000);

        // Restart latched mid-burst at 0x200
        do_burst("b4", -1);
        do_burst("b5", -1);
        wait_req("b6");
        check("restart_burst_addr", rd_addr, 24'h000200);
        wr_count = 0;
        do_burst("b6", 100);
        repeat (3) tick();
        check("restart_wr_count", wr_count, 256);
        wait_req("b7");
        check("restart_next_addr", rd_addr, 24'h000000);

        // Watermark: 512 blocks, 511 refills
        ack_req();
        fifo_wrusedw = 10'd512;
        send_beats(c_burst, -1, -1);
        model_advance();
        any_req = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            any_req |= rd_req;
        end
        check("wm_no_req", any_req, 0);
        check("wm_idle_busy", busy, 0);
        fifo_wrusedw = 10'd511;
        tick();
        check("wm_req_next_cycle", rd_req, 1);
        check("wm_rd_addr", rd_addr, 24'h000100);

        // Enable dropped mid-burst: burst completes, no new request
        fifo_wrusedw = 10'd0;
        ack_req();
        send_beats(100, -1, -1);
        enable = 1'b0;
        send_beats(c_burst - 100, -1, -1);
        model_advance();
        any_req = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            any_req |= rd_req;
        end
        check("disable_no_req", any_req, 0);
        check("disable_busy", busy, 0);

        // Restart in IDLE, then carry-out wrap at the top of the address space
        start_addr = 24'hFFFF00;
        end_addr   = 24'hFFFFFF;
        frame_restart = 1'b1;
        tick();
        frame_restart = 1'b0;
        exp_req_addr = start_addr;
        check("idle_restart_addr", rd_addr, 24'hFFFF00);
        enable = 1'b1;
        do_burst("b9", -1);
        wait_req("b10");
        check("carry_wrap_addr", rd_addr, 24'hFFFF00);

        // Restart while requesting, before ack
        start_addr = 24'h000000;
        end_addr   = 24'h0003FF;
        frame_restart = 1'b1;
        tick();
        frame_restart = 1'b0;
        exp_req_addr = start_addr;
        check("req_restart_addr", rd_addr, 24'h000000);
        check("req_restart_still_req", rd_req, 1);

        // Overrun then reset mid-burst
        ack_req();
        send_beats(50, -1, 5);
        check("overrun_sticky", err_overrun, 1);
        aclr = 1'b1;
        tick();
        exp_q.delete();
        model_err = 1'b0;
        check("midrst_rd_req", rd_req, 0);
        check("midrst_fifo_wrreq", fifo_wrreq, 0);
        check("midrst_busy", busy, 0);
        check("midrst_err", err_overrun, 0);
        check("midrst_fifo_data", fifo_data, 0);
        check("midrst_rd_addr", rd_addr, 24'h000000);
        aclr = 1'b0;
        exp_req_addr = start_addr;
        wr_count = 0;
        do_burst("post_rst", -1);
        repeat (3) tick();
        check("post_rst_wr_count", wr_count, 256);
        wait_req("post_rst_next");
        check("post_rst_next_addr", rd_addr, 24'h000100);

        repeat (3) tick();
        check("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sdram_rd_burst_ctrl.md
SDRAM_RD_BURST_CTRL -- requirements
Module: sdram_rd_burst_ctrl

Interface
REQ-001 Parameter ADDR_W, default 24: SDRAM word-address width.
REQ-002 Parameter BURST_LEN, default 256: words per read burst (power of two, at most 512).
REQ-003 Parameter FIFO_AW, default 10: read-FIFO usedw width (depth 1024).
REQ-004 Parameter LOW_WM, default 512: refill threshold on FIFO fill level.
REQ-005 clk  in  1: single clock (SDRAM controller clock, also the read-FIFO write clock).
REQ-006 aclr  in  1: synchronous, active-high reset.
REQ-007 enable  in  1: permits issuing new bursts.
REQ-008 frame_restart  in  1: one-cycle pulse; the next burst starts at start_addr.
REQ-009 start_addr, end_addr  in  ADDR_W: inclusive frame buffer region, sampled at burst issue.
REQ-010 fifo_wrusedw  in  FIFO_AW: read-FIFO write-side fill level.
REQ-011 rd_req  out  1: burst read request to the SDRAM controller.
REQ-012 rd_addr  out  ADDR_W: burst start address, stable while rd_req=1.
REQ-013 rd_ack  in  1: controller accepted the request.
REQ-014 rd_valid  in  1: one returned data word this cycle.
REQ-015 rd_data  in  16: returned data word.
REQ-016 fifo_wrreq  out  1: read-FIFO write strobe.
REQ-017 fifo_data  out  16: read-FIFO write data.
REQ-018 busy  out  1: a burst is outstanding.
REQ-019 err_overrun  out  1: sticky; a beat arrived while the FIFO was full.

Function
REQ-020 FSM states SHALL be IDLE, REQ, DATA, ADV.
- IDLE->REQ when enable=1 and fifo_wrusedw<LOW_WM.
- REQ->DATA on rd_ack.
- DATA->ADV when the BURST_LEN-th beat is received.
- ADV->IDLE after one cycle.
REQ-021 rd_req SHALL be 1 exactly in REQ; rd_addr SHALL hold the current burst address and not change until rd_ack.
REQ-022 fifo_wrreq/fifo_data SHALL be registered copies of rd_valid/rd_data: 1-cycle latency, no beat dropped or duplicated.
REQ-023 A beat counter SHALL count rd_valid only in DATA; rd_valid outside DATA SHALL be ignored.
REQ-024 In ADV, next address = rd_addr+BURST_LEN; if that exceeds end_addr, next address = start_addr (wrap).
REQ-025 Address arithmetic SHALL be done in ADDR_W+1 bits so that the end-of-address-space carry is detected as a wrap.
REQ-026 frame_restart arriving in IDLE or REQ-before-ack SHALL take effect immediately: rd_addr=start_addr.
REQ-027 frame_restart arriving in DATA or ADV SHALL be latched; the burst in flight completes, then the next address = start_addr.
REQ-028 busy SHALL be 1 in REQ and DATA.
REQ-029 err_overrun SHALL set when rd_valid=1 in DATA and fifo_wrusedw=all-ones; cleared only by aclr.
REQ-030 Deasserting enable SHALL NOT abort an outstanding burst; it only blocks the next IDLE->REQ.
REQ-031 The LOW_WM test guarantees FIFO room: LOW_WM+BURST_LEN SHALL be <= 2^FIFO_AW.

Reset
REQ-032 On aclr at a clk edge:
- state=IDLE, rd_addr=start_addr value at that edge;
- rd_req, fifo_wrreq, busy, err_overrun, beat counter, restart latch = 0;
- fifo_data = 0.
REQ-033 aclr asserted mid-burst SHALL drop rd_req and fifo_wrreq at that edge. The bench and integration SHALL also reset the SDRAM controller and the FIFO.

Structure
REQ-034 A shared package sdram_pkg SHALL hold the FSM state encoding and the default values of BURST_LEN, FIFO_AW and LOW_WM.
REQ-035 One sub-module, burst_addr_gen, SHALL hold the address register, wrap arithmetic and restart latch; the FSM and data path stay in the top module.

Verification
REQ-036 Cold start: start_addr=0, end_addr=0x3FF, usedw=0, enable=1 -> rd_req with rd_addr=0 within 2 cycles of reset release; after ack and 256 beats, 256 fifo_wrreq pulses, then rd_addr=0x100.
REQ-037 Wrap: four full bursts with usedw held at 0 -> the fifth rd_addr is 0x000.
REQ-038 Watermark: usedw=512 -> no rd_req for 100 cycles; usedw=511 -> rd_req on the next cycle.
REQ-039 Restart mid-burst: frame_restart at beat 100 of the burst at 0x200 -> burst completes with 256 beats, next rd_addr=0.
REQ-040 Overrun and reset: beat with usedw=0x3FF -> err_overrun=1 and stays 1; aclr mid-DATA -> all outputs 0 next cycle and the FSM restarts cleanly.
